// File: rtl/mem_ctrl_rw_pkg.sv
// Shared types and helpers for the mem_ctrl_rw memory controller.
package mem_ctrl_rw_pkg;

  typedef enum logic [0:0] {ST_INIT, ST_RUN} state_e;

  localparam int unsigned MAX_BYTES = 32;

  function automatic logic [MAX_BYTES-1:0] byte_parity(
    input logic [8*MAX_BYTES-1:0] data,
    input int unsigned            be_width
  );
    byte_parity = '0;
    for (int unsigned b = 0; b < MAX_BYTES; b++) begin
      if (b < be_width) byte_parity[b] = ^data[8*b +: 8];
    end
  endfunction

endpackage

// File: rtl/mem_ctrl_rw_array.sv
// Byte-enabled storage with registered read port.
// Optional per-byte even parity when MEM_CTRL_RW_PARITY_EN is defined.
module mem_ctrl_rw_array
  import mem_ctrl_rw_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int NB     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [NB-1:0]     wbe,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rerr
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

`ifdef MEM_CTRL_RW_PARITY_EN
  logic [NB-1:0]          par_q [DEPTH];
  logic [8*MAX_BYTES-1:0] wwide;
  logic [8*MAX_BYTES-1:0] rwide;
  logic [MAX_BYTES-1:0]   wpar;
  logic [MAX_BYTES-1:0]   rpar;
  logic                   rerr_q;

  always_comb begin
    wwide = '0;
    rwide = '0;
    wwide[DATA_W-1:0] = wdata;
    rwide[DATA_W-1:0] = mem_q[raddr];
  end

  assign wpar = byte_parity(wwide, NB);
  assign rpar = byte_parity(rwide, NB);

  // Parity bit follows its data byte's enable, so partial writes stay consistent.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) par_q[waddr][b] <= wpar[b];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rerr_q <= 1'b0;
    end else if (re) begin
      rerr_q <= |(rpar[NB-1:0] ^ par_q[raddr]);
    end
  end

  assign rerr = rerr_q;
`else
  assign rerr = 1'b0;
`endif

endmodule

// File: rtl/mem_ctrl_rw.sv
// Single-port memory controller: zero-init FSM plus valid/ready request/response.
// Define MEM_CTRL_RW_PARITY_EN for per-byte parity checking on reads.
module mem_ctrl_rw
  import mem_ctrl_rw_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int NB     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [NB-1:0]     req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  state_e            state_q;
  logic [ADDR_W-1:0] init_cnt_q;
  logic              init_done_q;
  logic              rsp_valid_q;

  logic              run;
  logic              hs;
  logic              rd_hs;
  logic              a_we;
  logic [ADDR_W-1:0] a_waddr;
  logic [DATA_W-1:0] a_wdata;
  logic [NB-1:0]     a_be;

  assign run       = (state_q == ST_RUN);
  assign req_ready = run && (!rsp_valid_q || rsp_ready);
  assign hs        = req_valid && req_ready;
  assign rd_hs     = hs && !req_we;

  // During INIT the write port is borrowed to clear one word per cycle.
  assign a_we    = run ? (hs && req_we) : 1'b1;
  assign a_waddr = run ? req_addr : init_cnt_q;
  assign a_wdata = run ? req_wdata : '0;
  assign a_be    = run ? req_be : '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (rd_hs) begin
            rsp_valid_q <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  mem_ctrl_rw_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_arr (
    .clk   (clk),
    .rst   (rst),
    .we    (a_we),
    .waddr (a_waddr),
    .wdata (a_wdata),
    .wbe   (a_be),
    .re    (rd_hs),
    .raddr (req_addr),
    .rdata (rsp_rdata),
    .rerr  (rsp_err)
  );

  assign rsp_valid = rsp_valid_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_mem_ctrl_rw.sv
// Randomised + directed bench for mem_ctrl_rw against a behavioural model.
module tb_mem_ctrl_rw;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int NB    = 4;
`ifdef MEM_CTRL_RW_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [NB-1:0] req_be;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          init_done;

  always #5 clk = ~clk;

  mem_ctrl_rw #(.DATA_W(DW), .DEPTH(DEPTH)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] m_mem [DEPTH];
  bit            m_bad [DEPTH];
  int            m_init_left;
  bit            m_rv;
  logic [DW-1:0] m_rd;
  bit            m_re;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_bad[i] = 1'b0;
    end
    m_init_left = DEPTH;
    m_rv = 1'b0;
  endtask

  function automatic bit m_ready();
    return (m_init_left == 0) && (!m_rv || rsp_ready);
  endfunction

  task automatic model_edge();
    bit rdy;
    rdy = m_ready();
    if (m_init_left > 0) begin
      m_init_left--;
    end else begin
      if (req_valid && rdy && req_we) begin
        for (int b = 0; b < NB; b++)
          if (req_be[b]) m_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
        if (req_be[0]) m_bad[req_addr] = 1'b0;
      end
      if (req_valid && rdy && !req_we) begin
        m_rv = 1'b1;
        m_rd = m_mem[req_addr];
        m_re = PAR && m_bad[req_addr];
      end else if (rsp_ready) begin
        m_rv = 1'b0;
      end
    end
  endtask

  // Called at a negedge with inputs already driven.
  task automatic step();
    #1;
    chk("req_ready", req_ready, m_ready());
    @(posedge clk);
    model_edge();
    #1;
    chk("init_done", init_done, m_init_left == 0);
    chk("rsp_valid", rsp_valid, m_rv);
    if (m_rv) begin
      chk("rsp_rdata", rsp_rdata, m_rd);
      chk("rsp_err", rsp_err, m_re);
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input bit we, input int a,
                       input logic [DW-1:0] d, input logic [NB-1:0] be,
                       input bit rr);
    req_valid = v;
    req_we    = we;
    req_addr  = AW'(a);
    req_wdata = d;
    req_be    = be;
    rsp_ready = rr;
  endtask

  task automatic reset_zero_check();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_init_done", init_done, 0);
  endtask

  task automatic run_init();
    int n;
    n = 0;
    drive(0, 0, 0, '0, '0, 1);
    while (!init_done && n < 200) begin
      if (!req_ready) n++;
      step();
    end
    chk("init_len", n, DEPTH);
  endtask

  int cnt;

  initial begin
    drive(0, 0, 0, '0, '0, 1);
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    reset_zero_check();
    rst = 1'b0;
    run_init();

    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, i, $urandom, '1, 1);
      step();
    end
    drive(0, 0, 0, '0, '0, 1);
    step();

    drive(1, 1, 5, 32'hDEADBEEF, 4'hF, 1);
    step();
    drive(1, 1, 5, 32'h000000AA, 4'b0001, 1);
    step();
    drive(1, 0, 5, '0, '0, 1);
    step();
    chk("rmw_literal", rsp_rdata, 32'hDEADBEAA);

    drive(1, 1, 3, 32'h12345678, 4'hF, 1);
    step();
    drive(1, 0, 3, '0, '0, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 9, '0, '0, 0);
      step();
      chk("stall_data", rsp_rdata, 32'h12345678);
    end
    #1;
    chk("stall_ready_lo", req_ready, 0);
    rsp_ready = 1'b1;
    #1;
    chk("stall_ready_hi", req_ready, 1);
    drive(0, 0, 0, '0, '0, 1);
    step();

    for (int i = 0; i < 10; i++) begin
      drive(1, 1, i, 32'(i) * 32'h11111111, 4'hF, 1);
      step();
    end
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, i, '0, '0, 1);
      step();
      if (rsp_valid && rsp_rdata == 32'(i) * 32'h11111111) cnt++;
    end
    chk("b2b_count", cnt, 10);
    drive(0, 0, 0, '0, '0, 1);
    step();

    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
            $urandom, NB'($urandom), $urandom_range(0, 3) != 0);
      step();
    end
    drive(0, 0, 0, '0, '0, 1);
    step();

    u_dut.u_arr.mem_q[7] = u_dut.u_arr.mem_q[7] ^ 32'h1;
    m_mem[7] = m_mem[7] ^ 32'h1;
    m_bad[7] = 1'b1;
    drive(1, 0, 7, '0, '0, 1);
    step();
    chk("parity_err", rsp_err, PAR);

    drive(1, 0, 5, '0, '0, 0);
    step();
    drive(0, 0, 0, '0, '0, 0);
    rst = 1'b1;
    #1;
    reset_zero_check();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_init();
    drive(1, 0, 5, '0, '0, 1);
    step();
    chk("post_rst_addr5", rsp_rdata, 0);
    drive(0, 0, 0, '0, '0, 1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl_rw.md
Name: mem_ctrl_rw

Overview:
- Parametrised single-port memory controller. Owns a DEPTH x DATA_W storage array and serves read/write requests over a valid/ready request channel and a valid/ready read-response channel.
- Generalises the fixed 32-bit rd_data/wr_data pass-through into the following:
  - addressable storage
  - byte-enabled writes
  - backpressure
  - zero-initialisation after reset
- Sits between a bus-side requester and on-chip storage in the memory subsystem.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 64, number of words; power of two, >= 2.
- ADDR_W, $clog2(DEPTH), word address width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller accepts request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data.
- req_be  input  DATA_W/8  byte enables for writes; ignored on reads.
- rsp_valid  output  1  read data valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_rdata  output  DATA_W  read data.
- rsp_err  output  1  read data parity error; see Optional Feature.
- init_done  output  1  zero-initialisation complete.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, FSM=INIT, init counter=0.
- Reset asserted mid-operation:
  - Any pending response is discarded.
  - The FSM restarts INIT.
  - Array contents are then rewritten to zero.
- FSM states:
  - INIT:
    - Writes 0 to address init_cnt each cycle; init_cnt increments.
    - At init_cnt==DEPTH-1, go to RUN and set init_done=1 next cycle.
    - Duration is exactly DEPTH cycles after reset deassertion.
    - req_ready=0 throughout.
  - RUN:
    - req_ready = !rsp_valid || rsp_ready.
    - Handshake occurs when req_valid && req_ready.
- Write (handshake, req_we=1):
  - Byte b of mem[req_addr] is updated at the clock edge when req_be[b]=1; other bytes are unchanged.
  - No response is generated.
  - req_be=0 is a legal no-op.
- Read (handshake, req_we=0):
  - mem[req_addr] is registered into rsp_rdata; rsp_valid=1 the next cycle (latency 1).
  - rsp_valid and rsp_rdata hold stable until rsp_valid && rsp_ready.
  - Back-to-back reads with rsp_ready=1 sustain 1 read/cycle.
- rsp_valid clears on the response handshake unless a new read is accepted in the same cycle, in which case the new data replaces it.
- A write accepted while a response is held does not alter the held rsp_rdata.
- Read of an address written in the previous cycle returns the new data.
- Read of an address written in the same cycle is impossible (single port, one request/cycle).
- req_* inputs are sampled only on handshake; values while req_ready=0 are don't-care.
- Address wrap: none; ADDR_W covers exactly DEPTH words.

Optional Feature:
- Macro: MEM_CTRL_RW_PARITY_EN.
- With macro defined:
  - Array stores one even-parity bit per byte, computed on the merged write data.
  - INIT writes parity 0, which is consistent with zero data.
  - On read, parity is recomputed; rsp_err=1 alongside rsp_valid if any byte mismatches.
  - rsp_err is registered with rsp_rdata and has the same hold rules.
  - Parity bits use the same byte enables as their data byte.
- Without macro: no parity storage; rsp_err tied to 0.

Decomposition:
- Package mem_ctrl_rw_pkg:
  - typedef enum logic [0:0] {ST_INIT, ST_RUN} state_e.
  - Function byte_parity(data, be_width) returning the per-byte parity vector.
- One sub-module: mem_ctrl_rw_array. Holds the byte-enabled storage (plus parity under the macro) with a synchronous write port and a registered read port.
- The FSM and handshake logic stay in the top module.

Test Plan:
- Reset release with DEPTH=64 -> req_ready=0 for 64 cycles, then init_done=1. Reading all addresses returns 0 with rsp_err=0.
- Write addr 5 data 0xDEADBEEF be=4'hF, then write addr 5 data 0x000000AA be=4'b0001, then read addr 5 -> rsp_rdata=0xDEADBEAA one cycle after the read handshake.
- Read addr 3 with rsp_ready=0 for 4 cycles -> rsp_valid and rsp_rdata stable, req_ready=0. Then raise rsp_ready -> handshake, with req_ready=1 in that same cycle.
- Ten back-to-back reads of addrs 0..9 holding prior writes i*0x11111111, rsp_ready=1 -> ten consecutive rsp_valid cycles with the matching data.
- Assert rst mid-stream with rsp_valid=1 -> all outputs zero immediately. After release, INIT reruns and the earlier write at addr 5 reads back 0.
- With MEM_CTRL_RW_PARITY_EN, force-flip a stored data bit of addr 7 via hierarchical deposit, then read -> rsp_err=1 with rsp_valid. Without the macro -> rsp_err stays 0.
